// File: rtl/cache_arbiter_pkg.sv
// Arbiter-wide types shared between the control block and the payload registers.
package cache_arbiter_pkg;

  // Identifies which L1 client owns (or last owned) the L2 port.
  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } client_e;

endpackage

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system data types.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_L1_bus;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of L1 client and L2 signals around the cache arbiter.
interface cache_arbiter_if;
  import lc3b_types::*;

  // I-cache client
  logic       i_mem_read;
  lc3b_word   i_mem_address;
  logic       i_mem_resp;
  pmem_L1_bus i_mem_rdata;

  // D-cache client
  logic       d_mem_read;
  logic       d_mem_write;
  lc3b_word   d_mem_address;
  pmem_L1_bus d_mem_wdata;
  logic       d_mem_resp;
  pmem_L1_bus d_mem_rdata;

  // L2 side
  logic       l2_mem_read;
  logic       l2_mem_write;
  lc3b_word   l2_mem_address;
  pmem_L1_bus l2_mem_wdata;
  logic       l2_mem_resp;
  pmem_L1_bus l2_mem_rdata;

  // Environment: L1 caches plus L2.
  modport master (
    output i_mem_read, i_mem_address,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output l2_mem_resp, l2_mem_rdata,
    input  i_mem_resp, i_mem_rdata, d_mem_resp, d_mem_rdata,
    input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  i_mem_read, i_mem_address,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  l2_mem_resp, l2_mem_rdata,
    output i_mem_resp, i_mem_rdata, d_mem_resp, d_mem_rdata,
    output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: picks a client in IDLE, waits for L2 completion, steers resp.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_mem_read,
  input  logic    d_mem_read,
  input  logic    d_mem_write,
  input  logic    l2_mem_resp,
  output logic    i_mem_resp,
  output logic    d_mem_resp,
  output logic    l2_mem_read,
  output logic    l2_mem_write,
  output logic    grant_load,
  output client_e grant_client
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } state_e;

  state_e  state_q, state_d;
  logic    write_q, write_d;
  client_e last_q, last_d;

  logic i_pend;
  logic d_pend;

  assign i_pend = i_mem_read;
  assign d_pend = d_mem_read | d_mem_write;

  // L2 command is purely a function of the registered state and kind.
  assign l2_mem_read  = (state_q != StIdle) & ~write_q;
  assign l2_mem_write = (state_q != StIdle) &  write_q;

  // Next-state, grant decision and completion steering.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    last_d       = last_q;
    grant_load   = 1'b0;
    grant_client = GrantI;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie the client not served last wins.
        if (d_pend && (!i_pend || last_q == GrantI)) begin
          grant_load   = 1'b1;
          grant_client = GrantD;
          state_d      = StServeD;
          write_d      = d_mem_write;  // read+write together is a writeback
          last_d       = GrantD;
        end else if (i_pend) begin
          grant_load   = 1'b1;
          grant_client = GrantI;
          state_d      = StServeI;
          write_d      = 1'b0;
          last_d       = GrantI;
        end
      end
      StServeI: begin
        if (l2_mem_resp) begin
          i_mem_resp = 1'b1;
          state_d    = StIdle;
        end
      end
      StServeD: begin
        if (l2_mem_resp) begin
          d_mem_resp = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, transaction kind and fairness flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      last_q  <= GrantI;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I/D) to single L2 arbiter; holds the granted request payload.
module cache_arbiter
  import lc3b_types::*;
  import cache_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);

  logic       i_mem_read;
  lc3b_word   i_mem_address;
  logic       d_mem_read;
  logic       d_mem_write;
  lc3b_word   d_mem_address;
  pmem_L1_bus d_mem_wdata;
  logic       l2_mem_resp;
  logic       i_mem_resp;
  logic       d_mem_resp;
  logic       l2_mem_read;
  logic       l2_mem_write;
  logic       grant_load;
  client_e    grant_client;

  lc3b_word   address_q, address_d;
  pmem_L1_bus wdata_q, wdata_d;

  assign i_mem_read    = bus.i_mem_read;
  assign i_mem_address = bus.i_mem_address;
  assign d_mem_read    = bus.d_mem_read;
  assign d_mem_write   = bus.d_mem_write;
  assign d_mem_address = bus.d_mem_address;
  assign d_mem_wdata   = bus.d_mem_wdata;
  assign l2_mem_resp   = bus.l2_mem_resp;

  cache_arbiter_control u_control (.*);

  assign bus.i_mem_resp     = i_mem_resp;
  assign bus.d_mem_resp     = d_mem_resp;
  assign bus.l2_mem_read    = l2_mem_read;
  assign bus.l2_mem_write   = l2_mem_write;
  assign bus.l2_mem_address = address_q;
  assign bus.l2_mem_wdata   = wdata_q;
  // Line data is broadcast; only the resp pulse tells a client it is theirs.
  assign bus.i_mem_rdata    = bus.l2_mem_rdata;
  assign bus.d_mem_rdata    = bus.l2_mem_rdata;

  // Capture the winner's payload on the grant edge; hold it otherwise.
  always_comb begin
    address_d = address_q;
    wdata_d   = wdata_q;
    if (grant_load) begin
      if (grant_client == GrantD) begin
        address_d = d_mem_address;
        wdata_d   = d_mem_wdata;
      end else begin
        address_d = i_mem_address;
        wdata_d   = '0;
      end
    end
  end

  // Payload registers toward L2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_q <= '0;
      wdata_q   <= '0;
    end else begin
      address_q <= address_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule
